// File: rtl/uart_send_if.sv
// Byte-producer to UART transmitter link: request/data from the producer,
// serial line and busy flag back from the transmitter.
interface uart_send_if;
  logic [7:0] data;
  logic       enable;
  logic       txd;
  logic       busy;

  modport master (
    output data,
    output enable,
    input  txd,
    input  busy
  );

  modport slave (
    input  data,
    input  enable,
    output txd,
    output busy
  );
endinterface

// File: rtl/uart_send.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks. A byte is accepted only in IDLE,
// on an edge with enable high; requests while busy are dropped, not queued.
module uart_send #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_send_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state_r;
  logic [7:0]       shreg_r;
  logic [2:0]       bit_idx_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic             txd_r;
  logic             busy_r;
  logic             baud_wrap_s;

  // Flag the last clock of the current serial bit.
  always_comb begin
    baud_wrap_s = 1'b0;
    if (baud_cnt_r == CNT_MAX) begin
      baud_wrap_s = 1'b1;
    end else begin
      baud_wrap_s = 1'b0;
    end
  end

  // Frame sequencer: accepts a byte in IDLE and shifts it out bit by bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      baud_cnt_r <= CNT_ZERO;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          baud_cnt_r <= CNT_ZERO;
          if (bus.enable) begin
            // Accept edge: capture the byte and drive the start bit now.
            shreg_r   <= bus.data;
            bit_idx_r <= 3'd0;
            txd_r     <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= START;
          end else begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        START: begin
          if (baud_wrap_s) begin
            baud_cnt_r <= CNT_ZERO;
            txd_r      <= shreg_r[0];
            shreg_r    <= {1'b0, shreg_r[7:1]};
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        DATA: begin
          if (baud_wrap_s) begin
            baud_cnt_r <= CNT_ZERO;
            if (bit_idx_r == 3'd7) begin
              txd_r   <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              txd_r     <= shreg_r[0];
              shreg_r   <= {1'b0, shreg_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        STOP: begin
          if (baud_wrap_s) begin
            // End of stop bit: go idle; this edge never accepts a new byte.
            baud_cnt_r <= CNT_ZERO;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= CNT_ZERO;
          txd_r      <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.txd  = txd_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_uart_send.sv
// Scoreboard bench for uart_send (CLKS_PER_BIT=4). Stimulus pushes the
// hand-computed line sequence of every frame that must appear; a monitor
// captures each frame from txd/busy and compares against the queue.
// Queue entry bit k is the k-th bit on the line (k=0 start, k=9 stop).
module tb_uart_send;

  logic clk;
  logic rst_n;

  uart_send_if bus ();

  uart_send #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [9:0] exp_q[$];
  int         n_checks;
  int         n_err;

  logic [9:0] mon_cap;
  logic [9:0] mon_exp;
  bit         mon_stable;
  bit         mon_busy_ok;
  bit         mon_abort;

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until busy drops; an expired bound is a failed check.
  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    chk(name, {31'd0, bus.busy}, 32'd0);
  endtask

  // One-cycle enable pulse launched just after a rising edge.
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.data   = b;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask

  // Monitor: capture each frame over 40 samples, then check against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.busy === 1'b1) begin
        mon_cap     = 10'd0;
        mon_cap[0]  = bus.txd;
        mon_stable  = 1'b1;
        mon_busy_ok = 1'b1;
        mon_abort   = 1'b0;
        for (int c = 1; c < 40; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            mon_abort = 1'b1;
            break;
          end
          if (bus.busy !== 1'b1) mon_busy_ok = 1'b0;
          if (c % 4 == 0) mon_cap[c / 4] = bus.txd;
          else if (bus.txd !== mon_cap[c / 4]) mon_stable = 1'b0;
        end
        if (!mon_abort) begin
          @(negedge clk);
          chk("idle_after_busy", {31'd0, bus.busy}, 32'd0);
          chk("idle_after_txd", {31'd0, bus.txd}, 32'd1);
          chk("bit_hold_4", {31'd0, mon_stable}, 32'd1);
          chk("busy_40", {31'd0, mon_busy_ok}, 32'd1);
          chk("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("frame_bits", {22'd0, mon_cap}, {22'd0, mon_exp});
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    int bad;
    n_checks   = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.data   = 8'h55;

    // Reset held for two edges with enable high.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_txd", {31'd0, bus.txd}, 32'd1);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    end
    #1;
    rst_n      = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);

    // 0x55: line 0,1,0,1,0,1,0,1,0,1
    exp_q.push_back(10'b1010101010);
    send(8'h55);
    bus.data = 8'hC9;
    wait_idle("idle_55");

    // Line must stay high between frames.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("idle_line", bad, 32'd0);

    // 0x07: line 0,1,1,1,0,0,0,0,0,1
    exp_q.push_back(10'b1000001110);
    send(8'h07);
    wait_idle("idle_07");

    // 0x00 frame with an ignored 0xFF request mid-frame.
    exp_q.push_back(10'b1000000000);
    send(8'h00);
    repeat (10) @(posedge clk);
    #1;
    bus.data   = 8'hFF;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    wait_idle("idle_00");
    repeat (5) @(negedge clk);
    chk("no_queued_busy", {31'd0, bus.busy}, 32'd0);
    chk("no_queued_txd", {31'd0, bus.txd}, 32'd1);

    // enable held high: two back-to-back 0xA5 frames, line 0,1,0,1,0,0,1,0,1,1
    exp_q.push_back(10'b1101001010);
    exp_q.push_back(10'b1101001010);
    @(posedge clk);
    #1;
    bus.data   = 8'hA5;
    bus.enable = 1'b1;
    repeat (42) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    wait_idle("idle_a5");
    repeat (3) @(posedge clk);

    // 0x81 aborted by reset during data bit 3 (bit 3 of 0x81 is 0).
    send(8'h81);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("abort_bit3", {31'd0, bus.txd}, 32'd0);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_txd", {31'd0, bus.txd}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    #1;
    rst_n = 1'b1;

    // 0xC3 after reset: line 0,1,1,0,0,0,0,1,1,1
    exp_q.push_back(10'b1110000110);
    send(8'hC3);
    wait_idle("idle_c3");
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
